// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: shared definitions for the multi-cycle execute ALU.
//   - ALUControl code constants (decoder output encoding)
//   - cnt_sel encoding for the Zbb count op (code ALU_CNT)
//   - FSM state encoding for alu_mc
package alu_mc_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_XOR  = 4'b1010;
  localparam logic [3:0] ALU_SLTU = 4'b1100;
  localparam logic [3:0] ALU_SE   = 4'b1101;
  localparam logic [3:0] ALU_SLL  = 4'b1110;
  localparam logic [3:0] ALU_CNT  = 4'b1111;

  typedef enum logic [1:0] {
    CNT_CLZ  = 2'b00,
    CNT_CTZ  = 2'b01,
    CNT_CPOP = 2'b10,
    CNT_BAD  = 2'b11
  } cnt_sel_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/alu_mc_comb.sv
// alu_mc_comb: single-cycle datapath and op decode for alu_mc.
// Optional macro ALU_MC_BARREL_SHIFT_EN: shifts resolved here in one cycle.
// Ports:
//   i_ctrl    ALUControl code
//   i_cnt_sel count-op select (only meaningful for ALU_CNT)
//   i_a, i_b  operands
//   o_result  single-cycle result (don't-care when o_multi=1)
//   o_illegal unsupported code / cnt_sel
//   o_multi   op needs the iterative path in alu_mc
module alu_mc_comb
  import alu_mc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      i_ctrl,
  input  logic [1:0]      i_cnt_sel,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_result,
  output logic            o_illegal,
  output logic            o_multi
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] w_shamt;
  assign w_shamt = i_b[SHW-1:0];

  always_comb begin
    o_result  = '0;
    o_illegal = 1'b0;
    o_multi   = 1'b0;
    case (i_ctrl)
      ALU_ADD:  o_result = i_a + i_b;
      ALU_SUB:  o_result = i_a - i_b;
      ALU_SE:   o_result = i_a - i_b;
      ALU_AND:  o_result = i_a & i_b;
      ALU_OR:   o_result = i_a | i_b;
      ALU_XOR:  o_result = i_a ^ i_b;
      ALU_SLT:  o_result = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      ALU_SLTU: o_result = {{(XLEN-1){1'b0}}, (i_a < i_b)};
`ifdef ALU_MC_BARREL_SHIFT_EN
      ALU_SLL:  o_result = i_a << w_shamt;
      ALU_SRL:  o_result = i_a >> w_shamt;
      ALU_SRA:  o_result = $unsigned($signed(i_a) >>> w_shamt);
`else
      // shamt=0 finishes immediately with the unshifted operand
      ALU_SLL, ALU_SRL, ALU_SRA: begin
        o_result = i_a;
        o_multi  = (w_shamt != '0);
      end
`endif
      ALU_CNT: begin
        if (i_cnt_sel == CNT_BAD) o_illegal = 1'b1;
        else                      o_multi   = 1'b1;
      end
      default:  o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle execute-stage ALU with valid/ready on both sides.
// Optional macro ALU_MC_BARREL_SHIFT_EN: shifts take the single-cycle path.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   op handshake (in_ready high only in IDLE)
//   alu_ctrl, cnt_sel   op code and count-op select
//   src_a, src_b        operands (shift amount in src_b low bits)
//   out_valid/out_ready result handshake
//   result, zero        registered result and result==0
//   illegal             unsupported op code or cnt_sel
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int CNTW = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [1:0]      cnt_sel,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam int SHW = $clog2(XLEN);

  state_e            r_state, w_state_nxt;
  logic [3:0]        r_op;
  cnt_sel_e          r_sel;
  logic [XLEN-1:0]   r_work, w_work_nxt;
  logic [CNTW-1:0]   r_iter;
  logic [CNTW-1:0]   r_cnt, w_cnt_nxt;
  logic              r_found, w_found_nxt;
  logic              w_bit;
  logic              w_last;
  logic [XLEN-1:0]   w_busy_res;
  logic [XLEN-1:0]   r_result;
  logic              r_zero, r_illegal;

  logic [XLEN-1:0]   w_comb_res;
  logic              w_comb_ill, w_multi;
  logic              w_accept;

  alu_mc_comb #(.XLEN(XLEN)) u_comb (
    .i_ctrl    (alu_ctrl),
    .i_cnt_sel (cnt_sel),
    .i_a       (src_a),
    .i_b       (src_b),
    .o_result  (w_comb_res),
    .o_illegal (w_comb_ill),
    .o_multi   (w_multi)
  );

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign zero      = r_zero;
  assign illegal   = r_illegal;
  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_iter == CNTW'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_multi ? S_BUSY : S_DONE;
      S_BUSY:  if (w_last) w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // One iteration step: shifts move r_work one bit; count ops consume one
  // bit per cycle (clz from the MSB, ctz/cpop from the LSB).
  always_comb begin
    w_bit       = 1'b0;
    w_work_nxt  = r_work;
    w_cnt_nxt   = r_cnt;
    w_found_nxt = r_found;
    if (r_op == ALU_CNT) begin
      if (r_sel == CNT_CLZ) begin
        w_bit      = r_work[XLEN-1];
        w_work_nxt = r_work << 1;
      end else begin
        w_bit      = r_work[0];
        w_work_nxt = r_work >> 1;
      end
      if (r_sel == CNT_CPOP) begin
        w_cnt_nxt = r_cnt + CNTW'(w_bit);
      end else begin
        if (!r_found && !w_bit) w_cnt_nxt = r_cnt + CNTW'(1);
        w_found_nxt = r_found | w_bit;
      end
    end else begin
      case (r_op)
        ALU_SLL: w_work_nxt = r_work << 1;
        ALU_SRL: w_work_nxt = r_work >> 1;
        ALU_SRA: w_work_nxt = {r_work[XLEN-1], r_work[XLEN-1:1]};
        default: w_work_nxt = r_work;
      endcase
    end
  end

  assign w_busy_res = (r_op == ALU_CNT) ? {{(XLEN-CNTW){1'b0}}, w_cnt_nxt}
                                        : w_work_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op      <= '0;
      r_sel     <= CNT_CLZ;
      r_work    <= '0;
      r_iter    <= '0;
      r_cnt     <= '0;
      r_found   <= 1'b0;
      r_result  <= '0;
      r_zero    <= 1'b1;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op    <= alu_ctrl;
            r_sel   <= cnt_sel_e'(cnt_sel);
            r_work  <= src_a;
            r_cnt   <= '0;
            r_found <= 1'b0;
            r_iter  <= (alu_ctrl == ALU_CNT) ? CNTW'(XLEN)
                                             : {{(CNTW-SHW){1'b0}}, src_b[SHW-1:0]};
            if (w_multi) begin
              r_illegal <= 1'b0;
            end else begin
              r_result  <= w_comb_res;
              r_zero    <= (w_comb_res == '0);
              r_illegal <= w_comb_ill;
            end
          end
        end
        S_BUSY: begin
          r_work  <= w_work_nxt;
          r_cnt   <= w_cnt_nxt;
          r_found <= w_found_nxt;
          r_iter  <= r_iter - CNTW'(1);
          if (w_last) begin
            r_result <= w_busy_res;
            r_zero   <= (w_busy_res == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Multi-cycle execute-stage ALU. Sits directly downstream of the ALU decoder and consumes its 4-bit ALUControl code plus operands.
- Simple ops complete in one cycle. Shifts and Zbb bit-count ops (clz/ctz/cpop) iterate over several cycles.
- Valid/ready handshakes on both sides let the core stall on long ops.
- Result is registered; a zero flag is produced for branch resolution.

Parameters:
- XLEN, 32, operand/result width (power of two, ≥8).
- CNTW, $clog2(XLEN)+1, width of the bit-count iteration counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operands and op are valid.
- in_ready  out  1  block can accept an op.
- alu_ctrl  in  4  ALUControl code from the decoder.
- cnt_sel  in  2  for code 1111 only: 00 = clz, 01 = ctz, 10 = cpop, 11 = illegal.
- src_a  in  XLEN  operand A.
- src_b  in  XLEN  operand B; shift amount is src_b[log2(XLEN)-1:0].
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- result  out  XLEN  registered result.
- zero  out  1  result == 0, registered with result.
- illegal  out  1  op code or cnt_sel was unsupported.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; out_valid=0, result=0, zero=1, illegal=0, counters 0.
  - Reset mid-BUSY or mid-DONE aborts the op; the result is discarded.
- Codes:
  - 0000 add, 0001 sub, 0010 and, 0011 or, 1010 xor: all mod 2^XLEN.
  - 0101 slt (signed): result = {0…,a<b}.
  - 1100 sltu: unsigned version of slt.
  - 1101 se: result = a − b. zero then means equal.
  - 1110 sll, 0110 srl, 0111 sra.
  - 1111 count op per cnt_sel.
  - Codes 0100, 1000, 1001, 1011: result=0, illegal=1, single-cycle.
- in_ready = (state==IDLE). An op is accepted on the edge where in_valid & in_ready.
- FSM IDLE/BUSY/DONE:
  - IDLE→DONE on accept for single-cycle ops, and for shifts with shamt=0. Result is registered on the same edge, so out_valid is high the next cycle (latency 1).
  - IDLE→BUSY on accept for shifts with shamt≠0:
    - The working register shifts one bit per cycle; sra fills with the sign bit.
    - BUSY for shamt cycles, then DONE. Latency = shamt+1.
  - IDLE→BUSY on accept for count ops:
    - Scans one bit per cycle for exactly XLEN cycles (fixed latency XLEN+1, no early exit).
    - clz counts leading zeros from the MSB and stops incrementing at the first 1.
    - ctz does the same from the LSB.
    - cpop counts all ones.
    - All-zero input gives clz = ctz = XLEN; cpop of all-ones is XLEN.
    - Result is zero-extended from CNTW bits.
  - DONE: out_valid=1. result, zero and illegal are held stable until out_valid & out_ready, then →IDLE.
  - No accept is possible in DONE, so back-to-back throughput is one op per 2 cycles minimum.
- Operands and alu_ctrl are captured at accept. Input changes during BUSY/DONE have no effect.
- cnt_sel=11 with code 1111: result=0, illegal=1, single-cycle.

Optional Feature:
- Macro ALU_MC_BARREL_SHIFT_EN.
- Defined: sll/srl/sra use a combinational barrel shifter and take the single-cycle path (latency 1 for any shamt). Count ops are unchanged.
- Undefined: iterative shifting as above.

Decomposition:
- Package alu_mc_pkg holds:
  - localparams for all ALUControl codes (ALU_ADD=4'b0000 … ALU_CNT=4'b1111);
  - the cnt_sel encoding enum (CNT_CLZ, CNT_CTZ, CNT_CPOP);
  - the FSM state enum.
- One sub-module, alu_mc_comb: purely combinational single-cycle ops plus the illegal decode. The barrel shifter also lives here when the macro is set.
- Iteration FSM, working registers and output registers stay in alu_mc.

Test Plan:
- Add wrap: code 0000, a=32'hFFFF_FFFF, b=1 → after 1 cycle out_valid=1, result=0, zero=1. With out_ready low for 3 cycles, result holds and in_ready stays 0.
- slt vs sltu: a=32'hFFFF_FFFE, b=2 → code 0101 gives result=1; code 1100 gives result=0.
- sra iterative (macro off): a=32'h8000_0000, b=4 → out_valid on cycle 5, result=32'hF800_0000. With b=0 → latency 1, result=a. With macro on, b=31 → latency 1, result=32'hFFFF_FFFF.
- Count ops, each latency 33:
  - a=32'h0000_0F00, cnt_sel=00 → result=20.
  - cnt_sel=01 → result=8.
  - cnt_sel=10 → result=4.
  - a=0, clz → result=32.
- Illegal code 1001 → latency 1, result=0, illegal=1. Code 1111 with cnt_sel=11 → same result.
- Reset mid-op: start cpop; drive rst_n=0 at cycle 10 → next cycle out_valid=0, in_ready=1, result=0, zero=1. A new add (3+4) then returns 7.
